// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: execute-stage integer ALU. Base RV ops complete in one
// cycle; RV M-extension multiply/divide/remainder run iteratively, one bit
// per cycle, with a valid/ready handshake on both sides.
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            fault,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [6:0]        funct7;
    logic              accept;
    logic              is_alt;
    logic [XLEN-1:0]   op_b;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res;
    logic [XLEN-1:0]   sc_result;
    logic              sc_fault;
    logic              start_calc;

    logic              a_signed, b_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_load;

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_res;
    logic [2:0]        m_funct3;
    logic [SHW-1:0]    count;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   final_res;

    assign funct7    = imm[11:5];
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;

    // Base integer ALU shared by reg-imm and reg-reg ops.
    always_comb begin
        op_b     = (alu_op == 3'd6) ? rs2 : imm;
        shamt    = op_b[SHW-1:0];
        is_alt   = (funct7 == F7_ALT);
        base_res = '0;
        case (funct3)
            3'b000:  base_res = (alu_op == 3'd6 && is_alt) ? rs1 - op_b : rs1 + op_b;
            3'b001:  base_res = rs1 << shamt;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op_b)};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, rs1 < op_b};
            3'b100:  base_res = rs1 ^ op_b;
            3'b101:  base_res = is_alt ? XLEN'($signed(rs1) >>> shamt) : rs1 >> shamt;
            3'b110:  base_res = rs1 | op_b;
            default: base_res = rs1 & op_b;
        endcase
    end

    // Decode: single-cycle result/fault, or a request to start an iterative op.
    always_comb begin
        sc_result  = '0;
        sc_fault   = 1'b0;
        start_calc = 1'b0;
        case (alu_op)
            3'd0: sc_result = imm;
            3'd1: sc_result = pc + XLEN'(4);
            3'd4: sc_result = rs2;
            3'd5: begin
                if ((funct3 == 3'b001 && funct7 != F7_BASE) ||
                    (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT))
                    sc_fault = 1'b1;
                else
                    sc_result = base_res;
            end
            3'd6: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    sc_result = base_res;
                else
                    sc_fault = 1'b1;
            end
            3'd7: begin
                if (funct7 != F7_MULDIV)
                    sc_fault = 1'b1;
                else if (funct3[2] && rs2 == '0)
                    sc_result = funct3[1] ? rs1 : '1;
                else if (funct3[2] && !funct3[0] && rs1 == SMIN && rs2 == '1)
                    sc_result = funct3[1] ? '0 : SMIN;
                else
                    start_calc = 1'b1;
            end
            default: sc_result = '0;
        endcase
    end

    // Operand magnitudes and result sign for the iterative engine.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        mag_a    = (a_signed && rs1[XLEN-1]) ? -rs1 : rs1;
        mag_b    = (b_signed && rs2[XLEN-1]) ? -rs2 : rs2;
        neg_load = 1'b0;
        case (funct3)
            3'b001, 3'b100: neg_load = rs1[XLEN-1] ^ rs2[XLEN-1];
            3'b010, 3'b110: neg_load = rs1[XLEN-1];
            default:        neg_load = 1'b0;
        endcase
    end

    // One shift-add or restoring-divide step, plus final sign fix-up and half select.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        step_next = m_funct3[2] ? div_next : mul_next;
        prod_fix  = neg_res ? -step_next : step_next;
        div_sel   = m_funct3[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
        final_res = '0;
        if (m_funct3[2])
            final_res = neg_res ? -div_sel : div_sel;
        else if (m_funct3[1:0] == 2'b00)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = start_calc ? CALC : DONE;
                CALC: if (count == '0) state_next = DONE;
                DONE: begin
                    if (accept)
                        state_next = start_calc ? CALC : DONE;
                    else if (out_ready)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Iterative engine: load on accept, step once per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            m_funct3 <= '0;
            count    <= '0;
        end else if (accept && start_calc) begin
            acc      <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd     <= funct3[2] ? mag_b : mag_a;
            neg_res  <= neg_load;
            m_funct3 <= funct3;
            count    <= SHW'(XLEN - 1);
        end else if (state == CALC) begin
            acc <= step_next;
            if (count != '0)
                count <= count - SHW'(1);
        end
    end

    // Result register: updated only on a single-cycle accept or iterative completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            fault   <= 1'b0;
        end else if (accept && !start_calc) begin
            alu_out <= sc_result;
            fault   <= sc_fault;
        end else if (state == CALC && count == '0 && !flush) begin
            alu_out <= final_res;
            fault   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed, table-driven bench for alu_muldiv_unit.
module tb_alu_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic [2:0]  funct3;
    logic [31:0] imm, rs1, rs2, pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        fault;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] exp_out;
        logic        exp_fault;
        logic [31:0] exp_lat;
    } vec_t;

    vec_t vecs[$];

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .imm(imm),
        .rs1(rs1), .rs2(rs2), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [2:0] op, input logic [2:0] f3, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                          input logic [31:0] eo, input logic ef, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.imm = im; v.rs1 = a; v.rs2 = b; v.pc = p;
        v.exp_out = eo; v.exp_fault = ef; v.exp_lat = 32'(lat);
        vecs.push_back(v);
    endtask

    task automatic driveOp(input vec_t v);
        alu_op = v.op; funct3 = v.f3; imm = v.imm;
        rs1 = v.rs1; rs2 = v.rs2; pc = v.pc;
        in_valid = 1'b1;
    endtask

    // Offer one op with out_ready high and wait (bounded) for its result.
    task automatic applyStimulus(input vec_t v, output int lat, output int busy_cnt);
        driveOp(v);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int   lat, busy_cnt, exp_busy;
        logic seen;
        vec_t v;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; funct3 = '0; imm = '0; rs1 = '0; rs2 = '0; pc = '0;

        // Reset values.
        #2;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset alu_out", alu_out, 32'd0);
        checkOutput("reset fault", 32'(fault), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table.
        addVec(3'd6, 3'b000, 32'h400, 32'd5, 32'd7, 0, 32'hFFFFFFFE, 0, 1);
        addVec(3'd5, 3'b000, 32'hFFFFFFFF, 32'd0, 0, 0, 32'hFFFFFFFF, 0, 1);
        addVec(3'd6, 3'b000, 32'h0, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 0, 1);
        addVec(3'd6, 3'b010, 32'h0, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 0, 1);
        addVec(3'd6, 3'b011, 32'h0, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 0, 1);
        addVec(3'd6, 3'b101, 32'h400, 32'h80000000, 32'h24, 0, 32'hF8000000, 0, 1);
        addVec(3'd5, 3'b101, 32'h4, 32'h80000000, 0, 0, 32'h08000000, 0, 1);
        addVec(3'd5, 3'b001, 32'd31, 32'd3, 0, 0, 32'h80000000, 0, 1);
        addVec(3'd6, 3'b100, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 1);
        addVec(3'd6, 3'b110, 32'h0, 32'hF0F0F0F0, 32'h0F0F0000, 0, 32'hFFFFF0F0, 0, 1);
        addVec(3'd6, 3'b111, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 1);
        addVec(3'd0, 3'b000, 32'h12345000, 0, 0, 0, 32'h12345000, 0, 1);
        addVec(3'd1, 3'b000, 0, 0, 0, 32'h100, 32'h104, 0, 1);
        addVec(3'd4, 3'b000, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1);
        addVec(3'd2, 3'b000, 32'h55, 32'h1, 32'h2, 0, 32'd0, 0, 1);
        addVec(3'd7, 3'b000, 32'h0, 32'd3, 32'd4, 0, 32'd0, 1, 1);
        addVec(3'd5, 3'b001, 32'h401, 32'd3, 0, 0, 32'd0, 1, 1);
        addVec(3'd6, 3'b111, 32'h400, 32'd3, 32'd1, 0, 32'd0, 1, 1);
        addVec(3'd7, 3'b001, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000000, 0, 33);
        addVec(3'd7, 3'b011, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0, 33);
        addVec(3'd7, 3'b000, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 0, 33);
        addVec(3'd7, 3'b100, 32'h20, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 0, 33);
        addVec(3'd7, 3'b110, 32'h20, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 0, 33);
        addVec(3'd7, 3'b101, 32'h20, 32'h80000000, 32'd0, 0, 32'hFFFFFFFF, 0, 1);
        addVec(3'd7, 3'b100, 32'h20, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 1);
        addVec(3'd7, 3'b110, 32'h20, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000, 0, 1);
        addVec(3'd7, 3'b111, 32'h20, 32'h55, 32'd0, 0, 32'h55, 0, 1);
        addVec(3'd7, 3'b010, 32'h20, 32'hFFFFFFFE, 32'd3, 0, 32'hFFFFFFFF, 0, 33);
        addVec(3'd7, 3'b111, 32'h20, 32'd100, 32'd7, 0, 32'd2, 0, 33);
        addVec(3'd7, 3'b000, 32'h20, 32'h12345678, 32'h10, 0, 32'h23456780, 0, 33);
        addVec(3'd7, 3'b100, 32'h20, 32'd7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 0, 33);

        // Back-to-back stream straight after reset.
        driveOp(vecs[0]);
        checkOutput("stream in_ready0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("stream valid0", 32'(out_valid), 32'd1);
        checkOutput("stream out0", alu_out, 32'hFFFFFFFE);
        checkOutput("stream in_ready1", 32'(in_ready), 32'd1);
        driveOp(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("stream valid1", 32'(out_valid), 32'd1);
        checkOutput("stream out1", alu_out, 32'hFFFFFFFF);
        checkOutput("stream fault1", 32'(fault), 32'd0);

        // Table loop.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v, lat, busy_cnt);
            exp_busy = (v.exp_lat > 1) ? int'(v.exp_lat) - 1 : 0;
            checkOutput($sformatf("vec%0d out", i), alu_out, v.exp_out);
            checkOutput($sformatf("vec%0d fault", i), 32'(fault), 32'(v.exp_fault));
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), v.exp_lat);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 32'(exp_busy));
        end

        // Backpressure on an iterative result.
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        driveOp('{op: 3'd7, f3: 3'b101, imm: 32'h20, rs1: 32'd100, rs2: 32'd7,
                  pc: 32'd0, exp_out: 32'd0, exp_fault: 1'b0, exp_lat: 32'd0});
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp latency", 32'(lat), 32'd33);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("bp hold out c%0d", c), alu_out, 32'd14);
            checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("bp still valid", 32'(out_valid), 32'd1);
        driveOp('{op: 3'd4, f3: 3'b000, imm: 32'h0, rs1: 32'd0, rs2: 32'h0000ABCD,
                  pc: 32'd0, exp_out: 32'd0, exp_fault: 1'b0, exp_lat: 32'd0});
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp next valid", 32'(out_valid), 32'd1);
        checkOutput("bp next out", alu_out, 32'h0000ABCD);
        @(posedge clk); #1;

        // Flush in the middle of a divide.
        driveOp('{op: 3'd7, f3: 3'b100, imm: 32'h20, rs1: 32'd1000, rs2: 32'd3,
                  pc: 32'd0, exp_out: 32'd0, exp_fault: 1'b0, exp_lat: 32'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("flush busy before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush busy after", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("flush no out_valid", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a divide.
        driveOp('{op: 3'd7, f3: 3'b100, imm: 32'h20, rs1: 32'd1000, rs2: 32'd3,
                  pc: 32'd0, exp_out: 32'd0, exp_fault: 1'b0, exp_lat: 32'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("rst busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst alu_out", alu_out, 32'd0);
        checkOutput("rst fault", 32'(fault), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Unit works again after the abort.
        applyStimulus(vecs[21], lat, busy_cnt);
        checkOutput("post-rst div out", alu_out, 32'hFFFFFFFD);
        checkOutput("post-rst div latency", 32'(lat), 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Sequential, parametrised successor of the execute-stage integer ALU. It executes RV base ALU ops in one cycle and RV M-extension multiply/divide/remainder ops iteratively, one bit per cycle. It uses a valid/ready handshake on both sides and sits between decode/register-read and writeback, stalling the pipeline through `in_ready` while an iterative op runs.

## Interface
- `XLEN`, 32: datapath width; must be a power of two, ≥8.
- `SHW`, $clog2(XLEN): shift-amount width; derived, not overridden.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of any op in flight or pending.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept an operation this cycle.
- `alu_op`  in  3  0 imm, 1 pc+4, 4 rs2, 5 reg-imm, 6 reg-reg, 7 M-extension; 2/3 reserved.
- `funct3`  in  3  sub-operation select.
- `imm`  in  XLEN  sign-extended immediate; `imm[11:5]` carries funct7 for ops 5/6/7.
- `rs1`, `rs2`, `pc`  in  XLEN each  operands.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer takes result.
- `alu_out`  out  XLEN  registered result.
- `fault`  out  1  illegal-encoding flag; qualified by `out_valid`.
- `busy`  out  1  high in CALC.

## Operation
- FSM states: IDLE, CALC, DONE.
- `in_ready` = (IDLE) or (DONE and `out_ready`). A handshake is `in_valid && in_ready && !flush`.

**Single-cycle ops**
- Covers ops 0/1/4/5/6, plus op 7 special cases.
- Ops 0/1/4/5/6 keep existing semantics: ADD/SUB/SLT/SLTU/XOR/OR/AND/SLL/SRL/SRA. Shift amount is the low SHW bits of the operand.
- Fault conditions:
  - funct7 other than 0000000 or 0100000: fault.
  - 0100000 is legal only for SUB (op 6), SRA, and SRAI.
- On a fault, `alu_out`=0 and `fault`=1.
- Reserved `alu_op` gives 0 with no fault.
- Result and fault are registered on handshake, and the state goes to DONE.

**Op 7 (M-extension)**
- Requires funct7=0000001, else fault, single-cycle.
- funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Special cases, single-cycle:
  - Divisor zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - DIV of −2^(XLEN−1) by −1 returns −2^(XLEN−1); REM returns 0.
- Otherwise the state goes to CALC. Operands are converted to magnitudes per signedness, and the result-negate flag is latched.
- Multiply: shift-add, 2·XLEN-bit accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle.
- Counter loads XLEN−1 and decrements each CALC cycle.
- On the cycle the counter is 0:
  - Apply sign fix-up (quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1)).
  - Select low or high half of the product.
  - Register the result and go to DONE.

**DONE**
- `out_valid`=1; `alu_out` and `fault` are held stable until `out_ready`.
- With `out_ready` and a new handshake in the same cycle: the new op is accepted (back-to-back).
- With `out_ready` and no new handshake: go to IDLE.

**Flush**
- Any state goes to IDLE next cycle; `out_valid` drops.
- Counter and accumulators are not cleared but are ignored.
- A flush has priority over `in_valid` in the same cycle.

**Arithmetic**
- All arithmetic is modulo 2^XLEN.
- MULH variants use the 2·XLEN product's upper half.

## Timing
- Reset values: state IDLE, `out_valid` 0, `alu_out` 0, `fault` 0, `busy` 0, counter 0. `in_ready` is 1 after reset.
- Reset asserted mid-CALC aborts the op immediately (asynchronously).
- Latency, handshake at cycle T:
  - Single-cycle ops: `out_valid` at T+1.
  - Iterative ops: `busy` high T+1..T+XLEN; `out_valid` at T+XLEN+1.
- Throughput: one single-cycle op per cycle while `out_ready` stays high.
- `in_ready` is low throughout CALC, and in DONE while `out_ready` is low.
- `alu_out` changes only on the cycle after a handshake or completion. It never glitches under a held `out_valid`.

## Test plan
- Reset-release and stream: `alu_op`=6, funct3=000, imm[11:5]=0100000, rs1=5, rs2=7, `out_ready`=1, then `alu_op`=5 funct3=000 imm=−1 rs1=0 on the next cycle → `alu_out`=0xFFFFFFFE at T+1 and 0xFFFFFFFF at T+2, `fault`=0, `in_ready` stays 1.
- MULH/MULHU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → MULH 0x00000000, MULHU 0xFFFFFFFE, MUL 0x00000001. `out_valid` exactly 33 cycles after accept; `busy` high 32 cycles.
- Division: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0x80000000/0 → 0xFFFFFFFF at T+1; DIV 0x80000000/−1 → 0x80000000 at T+1; REM of the same → 0.
- Backpressure: DIVU 100/7 with `out_ready`=0 for 10 cycles after `out_valid` → `alu_out`=14 held stable, `in_ready`=0. Raise `out_ready` together with a new `in_valid` → new op accepted that cycle.
- Faults: `alu_op`=7 with funct7=0000000 → `fault`=1, `alu_out`=0 at T+1. `alu_op`=5 funct3=001 imm[11:5]=0100000 → `fault`=1.
- Flush/reset mid-op: start DIV, assert `flush` at T+10 → `out_valid` never rises and `in_ready`=1 at T+11. Repeat with `rst_n` low at T+10 → all outputs return to reset values immediately.
